memory_stage: RTL and testbench

Memory stage of the 16-bit single-issue core. It sits directly downstream of the execute stage and consumes its ALU result as the data-memory address. It handles loads and stores against a variable-latency data memory using a request/done handshake, and stalls the upstream stages while an access is outstanding. It hands load data and a write-back valid pulse to the write-back stage.

---
 rtl/memory_pkg.sv | 20 ++
 rtl/mem_timeout_ctr.sv | 37 +++
 rtl/memory_stage.sv | 179 +++++++++++++++++
 tb/tb_memory_stage.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_pkg.sv
// memory_pkg: shared types and defaults for the memory stage.
// Optional feature macro honoured by memory_stage: MEM_ALIGN_CHECK_EN.
package memory_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    HALTED = 2'd2
  } state_e;

  localparam int TIMEOUT_DEFAULT = 255;
  localparam int CNT_W_DEFAULT   = 8;
  localparam int DATA_W          = 16;

  // A halfword access is misaligned when the byte address is odd.
  function automatic logic is_misaligned(input logic [DATA_W-1:0] addr);
    return addr[0];
  endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// mem_timeout_ctr: counts BUSY cycles of an outstanding data-memory access.
// o_reached is high in the BUSY cycle that is the TIMEOUT-th one since the
// clear, i.e. the count includes the cycle currently in progress.
module mem_timeout_ctr #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_reached
);

  // The register holds completed BUSY cycles, so the TIMEOUT-th cycle is
  // in progress when it equals TIMEOUT-1.
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;

  // Cycle counter: clear has priority over enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + ONE;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_reached = (r_cnt == LIMIT);

endmodule

// File: rtl/memory_stage.sv
// memory_stage: load/store stage of the 16-bit core with a req/done memory
// handshake, upstream stall, timeout abort and HALT retirement.
// Optional feature: define MEM_ALIGN_CHECK_EN to reject odd-address
// loads/stores with err instead of issuing them to memory.
module memory_stage
  import memory_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int CNT_W   = CNT_W_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic [15:0] aluOut,
  input  logic [15:0] writeData,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic        halt,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_done,
  input  logic [15:0] mem_rdata,
  output logic        stall,
  output logic        wbValid,
  output logic [15:0] wbData,
  output logic        halted,
  output logic        err
);

  state_e      r_state;
  state_e      w_state_nxt;
  logic        r_mem_wr;
  logic        w_mem_wr_nxt;
  logic [15:0] r_mem_addr;
  logic [15:0] w_mem_addr_nxt;
  logic [15:0] r_mem_wdata;
  logic [15:0] w_mem_wdata_nxt;
  logic        r_wb_valid;
  logic        w_wb_valid_nxt;
  logic [15:0] r_wb_data;
  logic [15:0] w_wb_data_nxt;
  logic        r_err;
  logic        w_err_nxt;
  logic        w_stall;
  logic        w_ctr_clr;
  logic        w_ctr_en;
  logic        w_reached;
  logic        w_is_mem;
  logic        w_misaligned;

  assign w_is_mem = memRead | memWrite;

`ifdef MEM_ALIGN_CHECK_EN
  assign w_misaligned = w_is_mem & is_misaligned(aluOut);
`else
  assign w_misaligned = 1'b0;
`endif

  mem_timeout_ctr #(
    .CNT_W  (CNT_W),
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_ctr_clr),
    .i_en     (w_ctr_en),
    .o_reached(w_reached)
  );

  // State, request latches and write-back outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_mem_wr    <= 1'b0;
      r_mem_addr  <= 16'h0000;
      r_mem_wdata <= 16'h0000;
      r_wb_valid  <= 1'b0;
      r_wb_data   <= 16'h0000;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_mem_wr    <= w_mem_wr_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_wb_valid  <= w_wb_valid_nxt;
      r_wb_data   <= w_wb_data_nxt;
      r_err       <= w_err_nxt;
    end
  end

  // Next-state and next-output logic; stall is combinational so the accept
  // cycle of a memory op already freezes upstream.
  always_comb begin
    w_state_nxt     = r_state;
    w_mem_wr_nxt    = r_mem_wr;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_wb_valid_nxt  = 1'b0;
    w_wb_data_nxt   = r_wb_data;
    w_err_nxt       = r_err;
    w_stall         = 1'b0;
    w_ctr_clr       = 1'b0;
    w_ctr_en        = 1'b0;

    case (r_state)
      IDLE: begin
        if (valid) begin
          if (halt) begin
            // HALT retires silently; stall starts from the next cycle.
            w_state_nxt = HALTED;
          end else if (w_is_mem) begin
            if (w_misaligned) begin
              w_err_nxt      = 1'b1;
              w_wb_valid_nxt = 1'b1;
              w_wb_data_nxt  = 16'h0000;
            end else begin
              w_mem_addr_nxt  = aluOut;
              w_mem_wdata_nxt = writeData;
              w_mem_wr_nxt    = memWrite;
              w_ctr_clr       = 1'b1;
              w_stall         = 1'b1;
              w_state_nxt     = BUSY;
            end
          end else begin
            w_wb_valid_nxt = 1'b1;
            w_wb_data_nxt  = aluOut;
          end
        end else begin
          w_wb_valid_nxt = 1'b0;
        end
      end

      BUSY: begin
        w_stall  = 1'b1;
        w_ctr_en = 1'b1;
        // Completion wins over a timeout landing in the same cycle.
        if (mem_done) begin
          if (r_mem_wr) begin
            w_wb_data_nxt = r_wb_data;
          end else begin
            w_wb_data_nxt = mem_rdata;
          end
          w_wb_valid_nxt = 1'b1;
          w_state_nxt    = IDLE;
        end else if (w_reached) begin
          w_err_nxt      = 1'b1;
          w_wb_valid_nxt = 1'b1;
          w_wb_data_nxt  = 16'h0000;
          w_state_nxt    = IDLE;
        end else begin
          w_state_nxt = BUSY;
        end
      end

      HALTED: begin
        w_stall     = 1'b1;
        w_state_nxt = HALTED;
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Reset must drop stall at once even if upstream still presents a memory op.
  assign stall     = w_stall & ~rst;
  assign mem_req   = (r_state == BUSY);
  assign halted    = (r_state == HALTED);
  assign mem_wr    = r_mem_wr;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign wbValid   = r_wb_valid;
  assign wbData    = r_wb_data;
  assign err       = r_err;

endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: directed bench for memory_stage (TIMEOUT=4) with a
// write-back scoreboard. Expectations follow MEM_ALIGN_CHECK_EN when defined.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [15:0] aluOut;
  logic [15:0] writeData;
  logic        memRead;
  logic        memWrite;
  logic        halt;
  logic        mem_done;
  logic [15:0] mem_rdata;
  logic        mem_req;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        stall;
  logic        wbValid;
  logic [15:0] wbData;
  logic        halted;
  logic        err;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_stall;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  memory_stage #(
    .TIMEOUT(4),
    .CNT_W  (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .valid    (valid),
    .aluOut   (aluOut),
    .writeData(writeData),
    .memRead  (memRead),
    .memWrite (memWrite),
    .halt     (halt),
    .mem_req  (mem_req),
    .mem_wr   (mem_wr),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_done (mem_done),
    .mem_rdata(mem_rdata),
    .stall    (stall),
    .wbValid  (wbValid),
    .wbData   (wbData),
    .halted   (halted),
    .err      (err)
  );

  task automatic check_w(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_b(input string tag, input logic obs, input logic exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    valid     = 1'b0;
    aluOut    = 16'h0000;
    writeData = 16'h0000;
    memRead   = 1'b0;
    memWrite  = 1'b0;
    halt      = 1'b0;
    mem_done  = 1'b0;
    mem_rdata = 16'h0000;
  endtask

  // Scoreboard: every write-back pulse must match the oldest expected value.
  always @(negedge clk) begin
    if (wbValid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_b("wb_unexpected", wbValid, 1'b0);
      end else begin
        check_w("wb_data", wbData, exp_q.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    mid();
    check_b("rst_mem_req", mem_req, 1'b0);
    check_b("rst_mem_wr", mem_wr, 1'b0);
    check_w("rst_mem_addr", mem_addr, 16'h0000);
    check_w("rst_mem_wdata", mem_wdata, 16'h0000);
    check_b("rst_stall", stall, 1'b0);
    check_b("rst_wbvalid", wbValid, 1'b0);
    check_w("rst_wbdata", wbData, 16'h0000);
    check_b("rst_halted", halted, 1'b0);
    check_b("rst_err", err, 1'b0);
    step();
    rst = 1'b0;

    // Non-memory op: one-cycle latency, no stall.
    step();
    valid = 1'b1; aluOut = 16'h1234; exp_q.push_back(16'h1234);
    mid();
    check_b("nm_stall_acc", stall, 1'b0);
    check_b("nm_wbv_early", wbValid, 1'b0);
    step();
    idle_inputs();
    mid();
    check_b("nm_wbv", wbValid, 1'b1);
    check_b("nm_stall_wb", stall, 1'b0);
    step();
    mid();
    check_b("nm_wbv_one_pulse", wbValid, 1'b0);

    // Load at 0x0040, mem_done in the third BUSY cycle.
    step();
    valid = 1'b1; memRead = 1'b1; aluOut = 16'h0040;
    n_stall = 0;
    mid();
    check_b("ld_acc_req", mem_req, 1'b0);
    n_stall = n_stall + (stall ? 1 : 0);
    for (int k = 1; k <= 3; k++) begin
      step();
      idle_inputs();
      if (k == 3) begin
        mem_done = 1'b1; mem_rdata = 16'hBEEF; exp_q.push_back(16'hBEEF);
      end
      mid();
      check_b("ld_req", mem_req, 1'b1);
      check_w("ld_addr", mem_addr, 16'h0040);
      check_b("ld_wr", mem_wr, 1'b0);
      check_b("ld_wbv_busy", wbValid, 1'b0);
      n_stall = n_stall + (stall ? 1 : 0);
    end
    step();
    idle_inputs();
    mid();
    check_b("ld_wbv", wbValid, 1'b1);
    check_b("ld_stall_after", stall, 1'b0);
    check_b("ld_req_after", mem_req, 1'b0);
    check_w("ld_stall_cycles", 16'(n_stall), 16'd4);

    // Store at 0x0010, mem_done in the first BUSY cycle; wbData unchanged.
    step();
    valid = 1'b1; memWrite = 1'b1; aluOut = 16'h0010; writeData = 16'hA5A5;
    mid();
    check_b("st_acc_stall", stall, 1'b1);
    step();
    idle_inputs();
    mem_done = 1'b1; mem_rdata = 16'hDEAD; exp_q.push_back(16'hBEEF);
    mid();
    check_b("st_req", mem_req, 1'b1);
    check_b("st_wr", mem_wr, 1'b1);
    check_w("st_wdata", mem_wdata, 16'hA5A5);
    check_w("st_addr", mem_addr, 16'h0010);
    step();
    idle_inputs();
    mid();
    check_b("st_wbv", wbValid, 1'b1);
    check_b("st_stall_after", stall, 1'b0);

    // mem_done in the TIMEOUT-th BUSY cycle completes without error.
    step();
    valid = 1'b1; memRead = 1'b1; aluOut = 16'h0022;
    mid();
    for (int k = 1; k <= 4; k++) begin
      step();
      idle_inputs();
      if (k == 4) begin
        mem_done = 1'b1; mem_rdata = 16'h5A5A; exp_q.push_back(16'h5A5A);
      end
      mid();
      check_b("bnd_req", mem_req, 1'b1);
    end
    step();
    idle_inputs();
    mid();
    check_b("bnd_wbv", wbValid, 1'b1);
    check_b("bnd_err", err, 1'b0);

    // Load with no mem_done: abort after 4 BUSY cycles.
    step();
    valid = 1'b1; memRead = 1'b1; aluOut = 16'h0050; exp_q.push_back(16'h0000);
    mid();
    for (int k = 1; k <= 4; k++) begin
      step();
      idle_inputs();
      mid();
      check_b("to_req", mem_req, 1'b1);
      check_b("to_err_early", err, 1'b0);
      check_b("to_wbv_early", wbValid, 1'b0);
    end
    step();
    mid();
    check_b("to_err", err, 1'b1);
    check_b("to_wbv", wbValid, 1'b1);
    check_b("to_req_after", mem_req, 1'b0);
    check_b("to_stall_after", stall, 1'b0);

    // err is sticky across later ops.
    step();
    valid = 1'b1; aluOut = 16'h7777; exp_q.push_back(16'h7777);
    mid();
    step();
    idle_inputs();
    mid();
    check_b("sticky_wbv", wbValid, 1'b1);
    check_b("sticky_err", err, 1'b1);

    // mem_done outside BUSY is ignored.
    step();
    mem_done = 1'b1; mem_rdata = 16'hFFFF;
    mid();
    check_b("stray_req", mem_req, 1'b0);
    check_b("stray_stall", stall, 1'b0);
    step();
    idle_inputs();
    mid();
    check_b("stray_wbv", wbValid, 1'b0);

    // Odd-address load.
    step();
    valid = 1'b1; memRead = 1'b1; aluOut = 16'h0003;
`ifdef MEM_ALIGN_CHECK_EN
    exp_q.push_back(16'h0000);
    mid();
    check_b("al_stall", stall, 1'b0);
    step();
    idle_inputs();
    mid();
    check_b("al_wbv", wbValid, 1'b1);
    check_b("al_req", mem_req, 1'b0);
    check_b("al_err", err, 1'b1);
`else
    mid();
    check_b("odd_stall", stall, 1'b1);
    step();
    idle_inputs();
    mem_done = 1'b1; mem_rdata = 16'h0303; exp_q.push_back(16'h0303);
    mid();
    check_b("odd_req", mem_req, 1'b1);
    check_w("odd_addr", mem_addr, 16'h0003);
    step();
    idle_inputs();
    mid();
    check_b("odd_wbv", wbValid, 1'b1);
`endif

    // HALT: absorbing, later ops ignored.
    step();
    valid = 1'b1; halt = 1'b1; aluOut = 16'h0099;
    mid();
    check_b("h_acc_stall", stall, 1'b0);
    check_b("h_acc_halted", halted, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      step();
      idle_inputs();
      valid = 1'b1; memRead = (k % 2 == 1); aluOut = 16'h0100 + 16'(k);
      mem_done = 1'b1;
      mid();
      check_b("h_halted", halted, 1'b1);
      check_b("h_stall", stall, 1'b1);
      check_b("h_req", mem_req, 1'b0);
      check_b("h_wbv", wbValid, 1'b0);
    end
    step();
    idle_inputs();
    rst = 1'b1;
    #1;
    check_b("h_rst_halted", halted, 1'b0);
    check_b("h_rst_stall", stall, 1'b0);
    check_b("h_rst_err", err, 1'b0);
    step();
    rst = 1'b0;

    // Reset in the middle of a store abandons it immediately.
    step();
    valid = 1'b1; memWrite = 1'b1; aluOut = 16'h0020; writeData = 16'h1111;
    mid();
    step();
    idle_inputs();
    mid();
    check_b("ra_req_busy", mem_req, 1'b1);
    check_b("ra_stall_busy", stall, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_b("ra_req", mem_req, 1'b0);
    check_b("ra_stall", stall, 1'b0);
    check_w("ra_addr", mem_addr, 16'h0000);
    step();
    rst = 1'b0;
    mid();
    check_b("ra_wbv", wbValid, 1'b0);
    step();
    mid();

    check_w("q_empty", 16'(exp_q.size()), 16'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
